i2c_master_ctrl: RTL and testbench

- Bus-side transaction engine directly upstream of the I2C memory slave in `top`.
- Accepts a single-byte request (7-bit word address, R/W, write data) from the `mainbus` command side.
- Serialises the request onto SCL/SDA as one I2C frame: START, address, R/W, ACK, data, ACK/NACK, STOP.
- Returns read data and completion/error status.

---
 rtl/i2c_master_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address, R/W, ACK, data, ACK/NACK, STOP.
// One request per frame; results are reported by a one-cycle done pulse.
module i2c_master_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_en,
  input  logic                  r_w,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_err,
  output logic                  scl,
  output logic                  sda_oe,
  input  logic                  sda_in,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_RW, S_ACK1, S_DATA, S_ACK2, S_STOP, S_DONE
  } state_e;

  localparam int BIT_CYC = 4 * CLK_DIV;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int MAXW    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BW      = $clog2(MAXW + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(3 * CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_Q2     = CW'(2 * CLK_DIV);
  localparam logic [CW-1:0] CNT_Q3     = CW'(3 * CLK_DIV);
  localparam logic [BW-1:0] ADDR_LAST  = BW'(ADDR_WIDTH - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rw_q, rw_d;
  logic                    ack_err_q, ack_err_d;
  logic                    scl_q, scl_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end, sample;
  logic [1:0]              drv;

  // Line levels for a given position in the frame: {scl, sda_oe}.
  function automatic logic [1:0] line_drive(input state_e st, input logic [CW-1:0] cnt,
                                            input logic a_msb, input logic w_msb,
                                            input logic rw);
    logic hi;
    logic s;
    logic o;
    hi = (cnt >= CNT_Q2);
    s  = hi;
    o  = 1'b0;
    case (st)
      S_IDLE, S_DONE: s = 1'b1;
      S_START: begin
        s = 1'b1;
        o = hi;
      end
      S_ADDR:  o = ~a_msb;
      S_RW:    o = ~rw;
      S_DATA:  o = ~rw & ~w_msb;
      S_STOP:  o = (cnt < CNT_Q3);
      default: ;
    endcase
    return {s, o};
  endfunction

  // Handshake: m_en is a strobe taken only while IDLE (busy=0, done=0);
  // any m_en seen while busy or during the done cycle is dropped, never queued.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    ack_err_d = ack_err_q;
    bit_end   = (cnt_q == CNT_LAST);
    sample    = (cnt_q == CNT_SAMPLE);

    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (m_en) begin
          addr_d    = addr;
          wdata_d   = wdata;
          rw_d      = r_w;
          ack_err_d = 1'b0;
          cnt_d     = '0;
          bit_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_ADDR;
      S_ADDR: begin
        if (bit_end) begin
          addr_d = addr_q << 1;
          if (bit_q == ADDR_LAST) begin
            bit_d   = '0;
            state_d = S_RW;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_RW: if (bit_end) state_d = S_ACK1;
      S_ACK1: begin
        if (sample && sda_in) ack_err_d = 1'b1;
        // The sample point always precedes the bit end, so ack_err_q is current here.
        if (bit_end) state_d = ack_err_q ? S_STOP : S_DATA;
      end
      S_DATA: begin
        if (sample && rw_q) rx_d = {rx_q[DATA_WIDTH-2:0], sda_in};
        if (bit_end) begin
          wdata_d = wdata_q << 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = S_ACK2;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_ACK2: begin
        if (sample && sda_in && !rw_q) ack_err_d = 1'b1;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_DONE;
          if (rw_q && !ack_err_q) rdata_d = rx_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so SCL/SDA never glitch.
    drv      = line_drive(state_d, cnt_d, addr_d[ADDR_WIDTH-1], wdata_d[DATA_WIDTH-1], rw_d);
    scl_d    = drv[1];
    sda_oe_d = drv[0];
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_err   = ack_err_q;
  assign scl       = scl_q;
  assign sda_oe    = sda_oe_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1) checked every
// cycle against a slot-level frame model, plus a wire monitor acting as slave memory.
module tb_i2c_master_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       m_en4 = 1'b0, r_w4 = 1'b0, sda_in4 = 1'b1;
  logic [6:0] addr4 = '0;
  logic [7:0] wdata4 = '0, rdata4;
  logic       busy4, done4, ack_err4, scl4, sda_oe4;
  logic [3:0] dbg4;

  logic       m_en1 = 1'b0, r_w1 = 1'b0, sda_in1 = 1'b1;
  logic [6:0] addr1 = '0;
  logic [7:0] wdata1 = '0, rdata1;
  logic       busy1, done1, ack_err1, scl1, sda_oe1;
  logic [3:0] dbg1;

  i2c_master_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .m_en(m_en4), .r_w(r_w4), .addr(addr4), .wdata(wdata4),
    .rdata(rdata4), .busy(busy4), .done(done4), .ack_err(ack_err4), .scl(scl4),
    .sda_oe(sda_oe4), .sda_in(sda_in4), .state_dbg(dbg4)
  );

  i2c_master_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .m_en(m_en1), .r_w(r_w1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .busy(busy1), .done(done1), .ack_err(ack_err1), .scl(scl1),
    .sda_oe(sda_oe1), .sda_in(sda_in1), .state_dbg(dbg1)
  );

  // ---------------- scoreboard state ----------------
  // Per-cycle expectation: {sda_in to drive, busy, done, scl, sda_oe}.
  logic [4:0]  exp4_q[$], exp1_q[$];
  // Per-frame result info: {rd, ack_addr, ack_data, byte}.
  logic [10:0] res4_q[$], res1_q[$];
  logic [7:0]  mdl_rdata4 = '0, mdl_rdata1 = '0;
  logic [7:0]  model_mem [128];
  logic [7:0]  mon_mem [128];
  logic [6:0]  mon_last_addr = '0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: list of bit slots, each a 4-quarter scl/low pattern, expanded to cycles.
  task automatic push_frame(input int which, input logic rd, input logic [6:0] a,
                            input logic [7:0] d, input logic ack_a, input logic ack_d);
    logic [3:0] s_scl[$];
    logic [3:0] s_low[$];
    logic       s_sda[$];
    logic [4:0] f[$];
    int         c;
    c = (which == 4) ? 4 : 1;
    s_scl.push_back(4'b1111); s_low.push_back(4'b1100); s_sda.push_back(1'b1);
    for (int i = 6; i >= 0; i--) begin
      s_scl.push_back(4'b1100); s_low.push_back(a[i] ? 4'b0000 : 4'b1111); s_sda.push_back(1'b1);
    end
    s_scl.push_back(4'b1100); s_low.push_back(rd ? 4'b0000 : 4'b1111); s_sda.push_back(1'b1);
    s_scl.push_back(4'b1100); s_low.push_back(4'b0000); s_sda.push_back(!ack_a);
    if (ack_a) begin
      for (int i = 7; i >= 0; i--) begin
        s_scl.push_back(4'b1100);
        s_low.push_back((rd || d[i]) ? 4'b0000 : 4'b1111);
        s_sda.push_back(rd ? d[i] : 1'b1);
      end
      s_scl.push_back(4'b1100); s_low.push_back(4'b0000); s_sda.push_back(rd ? 1'b1 : !ack_d);
    end
    s_scl.push_back(4'b1100); s_low.push_back(4'b0111); s_sda.push_back(1'b1);
    f.push_back(5'b1_0010);
    foreach (s_scl[k]) begin
      for (int q = 0; q < 4; q++) begin
        for (int cc = 0; cc < c; cc++) begin
          f.push_back({s_sda[k], 1'b1, 1'b0, s_scl[k][q], s_low[k][q]});
        end
      end
    end
    f.push_back(5'b1_0110);
    if (which == 4) begin
      foreach (f[k]) exp4_q.push_back(f[k]);
      res4_q.push_back({rd, ack_a, ack_d, d});
    end else begin
      foreach (f[k]) exp1_q.push_back(f[k]);
      res1_q.push_back({rd, ack_a, ack_d, d});
    end
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    logic [4:0]  e4, e1;
    logic [10:0] r;
    forever begin
      @(posedge clk);
      if (reset) begin
        exp4_q.delete(); exp1_q.delete(); res4_q.delete(); res1_q.delete();
        mdl_rdata4 = '0; mdl_rdata1 = '0;
      end
      #1;
      sda_in4 = (exp4_q.size() > 0) ? exp4_q[0][4] : 1'b1;
      sda_in1 = (exp1_q.size() > 0) ? exp1_q[0][4] : 1'b1;
      @(negedge clk);
      e4 = (exp4_q.size() > 0) ? exp4_q.pop_front() : 5'b1_0010;
      if (e4[2]) begin
        r = (res4_q.size() > 0) ? res4_q.pop_front() : '0;
        if (r[10] && r[9]) mdl_rdata4 = r[7:0];
        check("ack_err4", ack_err4, !r[9] || (!r[10] && !r[8]));
      end
      check("wire4", {busy4, done4, scl4, sda_oe4}, e4[3:0]);
      check("rdata4", rdata4, mdl_rdata4);
      e1 = (exp1_q.size() > 0) ? exp1_q.pop_front() : 5'b1_0010;
      if (e1[2]) begin
        r = (res1_q.size() > 0) ? res1_q.pop_front() : '0;
        if (r[10] && r[9]) mdl_rdata1 = r[7:0];
        check("ack_err1", ack_err1, !r[9] || (!r[10] && !r[8]));
      end
      check("wire1", {busy1, done1, scl1, sda_oe1}, e1[3:0]);
      check("rdata1", rdata1, mdl_rdata1);
    end
  end

  // ---------------- wire monitor / slave memory (dut4) ----------------
  initial begin : monitor
    logic prev_scl, prev_line, line;
    logic bits_q[$];
    logic [6:0] a;
    logic [7:0] d;
    prev_scl = 1'b1;
    prev_line = 1'b1;
    forever begin
      @(negedge clk);
      line = !sda_oe4 && sda_in4;
      if (prev_scl && scl4 && prev_line && !line) begin
        bits_q.delete();
      end else if (!prev_scl && scl4) begin
        bits_q.push_back(line);
      end else if (prev_scl && scl4 && !prev_line && line && bits_q.size() == 19) begin
        a = '0;
        d = '0;
        for (int i = 0; i < 7; i++) a = {a[5:0], bits_q[i]};
        for (int i = 9; i < 17; i++) d = {d[6:0], bits_q[i]};
        mon_last_addr = a;
        if (!bits_q[7] && !bits_q[8] && !bits_q[17]) mon_mem[a] = d;
      end
      prev_scl = scl4;
      prev_line = line;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run4(input logic rd, input logic [6:0] a, input logic [7:0] d,
                      input logic ack_a, input logic ack_d, input int exp_done,
                      input int pulse_at, input int reset_at);
    int first_done, n_done, last;
    @(posedge clk); #2;
    m_en4 = 1'b1; r_w4 = rd; addr4 = a; wdata4 = d;
    push_frame(4, rd, a, d, ack_a, ack_d);
    @(posedge clk); #2;
    m_en4  = 1'b0;
    r_w4   = 1'($urandom_range(0, 1));
    addr4  = 7'($urandom_range(0, 127));
    wdata4 = 8'($urandom_range(0, 255));
    last = (reset_at > 0) ? reset_at + 1 : exp_done + 3;
    first_done = 0;
    n_done = 0;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (done4) begin
        n_done++;
        if (first_done == 0) first_done = n;
      end
      m_en4 = (n == pulse_at);
      if (n == pulse_at) addr4 = a ^ 7'h55;
      if (reset_at > 0 && n == reset_at) reset = 1'b1;
      if (reset_at > 0 && n == reset_at + 1) begin
        check("rst_mid_scl", scl4, 1'b1);
        check("rst_mid_sda_oe", sda_oe4, 1'b0);
        check("rst_mid_busy", busy4, 1'b0);
        check("rst_mid_rdata", rdata4, 8'h00);
        reset = 1'b0;
      end
    end
    if (reset_at > 0) begin
      check("no_done_after_reset", n_done, 0);
    end else begin
      check("done_cycle", first_done, exp_done);
      check("done_count", n_done, 1);
      if (!rd && ack_a && ack_d) model_mem[a] = d;
    end
  endtask

  task automatic run_b2b1(input logic [6:0] a1, input logic [7:0] d1,
                          input logic [6:0] a2, input logic [7:0] d2);
    int first_done, second_done, n_done;
    @(posedge clk); #2;
    m_en1 = 1'b1; r_w1 = 1'b0; addr1 = a1; wdata1 = d1;
    push_frame(1, 1'b0, a1, d1, 1'b1, 1'b1);
    push_frame(1, 1'b0, a2, d2, 1'b1, 1'b1);
    @(posedge clk); #2;
    addr1 = a2; wdata1 = d2;
    first_done = 0; second_done = 0; n_done = 0;
    for (int n = 1; n <= 170; n++) begin
      @(negedge clk);
      if (done1) begin
        n_done++;
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
      end
      if (n == 84) m_en1 = 1'b0;
    end
    check("b2b_done1", first_done, 81);
    check("b2b_done2", second_done, 163);
    check("b2b_count", n_done, 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic       rd, ack_a, ack_d;
    logic [6:0] a;
    logic [7:0] d;
    for (int i = 0; i < 128; i++) begin
      model_mem[i] = '0;
      mon_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_scl", scl4, 1'b1);
    check("rst_sda_oe", sda_oe4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_ack_err", ack_err4, 1'b0);
    check("rst_rdata", rdata4, 8'h00);
    @(posedge clk); #2;
    reset = 1'b0;

    run4(1'b0, 7'd100, 8'hA5, 1'b1, 1'b1, 321, 0, 0);
    check("mem100", mon_mem[100], 8'hA5);
    check("mon_addr100", mon_last_addr, 7'd100);
    check("write_ack_err", ack_err4, 1'b0);

    run4(1'b1, 7'd120, 8'h3C, 1'b1, 1'b1, 321, 0, 0);
    check("read_rdata", rdata4, 8'h3C);

    run4(1'b1, 7'd55, 8'hC3, 1'b0, 1'b1, 177, 0, 0);
    check("nack_ack_err", ack_err4, 1'b1);
    check("nack_rdata_held", rdata4, 8'h3C);

    run4(1'b0, 7'd9, 8'h00, 1'b1, 1'b1, 321, 0, 217);
    run4(1'b0, 7'd1, 8'h5A, 1'b1, 1'b1, 321, 0, 0);
    check("mem1", mon_mem[1], 8'h5A);

    run4(1'b0, 7'd33, 8'h96, 1'b1, 1'b1, 321, 100, 0);
    check("pulse_addr", mon_last_addr, 7'd33);

    run4(1'b0, 7'd77, 8'h11, 1'b1, 1'b0, 321, 0, 0);
    check("data_nack_ack_err", ack_err4, 1'b1);

    for (int t = 0; t < 6; t++) begin
      rd    = 1'($urandom_range(0, 1));
      a     = 7'($urandom_range(0, 127));
      d     = 8'($urandom_range(0, 255));
      ack_a = ($urandom_range(0, 3) != 0);
      ack_d = ($urandom_range(0, 3) != 0);
      run4(rd, a, d, ack_a, ack_d, ack_a ? 321 : 177, 0, 0);
    end

    run_b2b1(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
             7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));

    for (int i = 0; i < 128; i++) check("slave_mem", mon_mem[i], model_mem[i]);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
